// File: rtl/vec_ram_ctrl.sv
// Burst controller between a command/write-data/read-data stream interface and a
// single-port vector RAM with one-cycle read latency.
module vec_ram_ctrl #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 256,
  parameter int unsigned LW = 4,
  localparam int unsigned BW = DW / 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_we_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [LW-1:0] cmd_len_i,
  input  logic [BW-1:0] cmd_be_i,
  input  logic          wd_valid_i,
  output logic          wd_ready_o,
  input  logic [DW-1:0] wd_data_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_last_o,
  output logic          busy_o,
  output logic          ram_en_o,
  output logic [BW-1:0] ram_we_o,
  output logic [AW-1:0] ram_addr_o,
  output logic [DW-1:0] ram_d_o,
  input  logic [DW-1:0] ram_d_i
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  state_e        state_q;
  logic [AW-1:0] addr_q;
  logic [LW-1:0] len_q;
  logic [BW-1:0] be_q;
  logic          inflight_q;
  logic          inflight_last_q;

  logic [DW-1:0] fifo_data_q [2];
  logic [1:0]    fifo_last_q;
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    count_q;

  logic          cmd_accept;
  logic          wr_fire;
  logic          rd_issue;
  logic          beat_last;
  logic          push;
  logic          pop;
  logic [2:0]    pending;

  always_comb begin
    cmd_ready_o = (state_q == StIdle) & ~rst_i;
    cmd_accept  = cmd_valid_i & cmd_ready_o;
    wd_ready_o  = (state_q == StWrite);
    wr_fire     = wd_ready_o & wd_valid_i;
    rd_valid_o  = (count_q != 2'd0);
    pop         = rd_valid_o & rd_ready_i;
    push        = inflight_q;
    // Reads already committed to the FIFO once the current pop is accounted for.
    pending     = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    rd_issue    = (state_q == StRead) && (pending < 3'd2);
    beat_last   = (len_q == '0);
  end

  always_comb begin
    ram_en_o   = wr_fire | rd_issue;
    ram_we_o   = wr_fire ? be_q : '0;
    ram_addr_o = addr_q;
    ram_d_o    = wr_fire ? wd_data_i : '0;
    rd_data_o  = rd_valid_o ? fifo_data_q[rd_ptr_q] : '0;
    rd_last_o  = rd_valid_o & fifo_last_q[rd_ptr_q];
    busy_o     = (state_q != StIdle) | inflight_q | rd_valid_o;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      len_q           <= '0;
      be_q            <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= rd_issue;
      inflight_last_q <= rd_issue & beat_last;
      unique case (state_q)
        StIdle: begin
          if (cmd_accept) begin
            addr_q  <= cmd_addr_i;
            len_q   <= cmd_len_i;
            be_q    <= cmd_be_i;
            state_q <= cmd_we_i ? StWrite : StRead;
          end
        end
        StWrite: begin
          if (wr_fire) begin
            addr_q <= addr_q + AW'(1);
            len_q  <= len_q - LW'(1);
            if (beat_last) state_q <= StIdle;
          end
        end
        StRead: begin
          if (rd_issue) begin
            addr_q <= addr_q + AW'(1);
            len_q  <= len_q - LW'(1);
            if (beat_last) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Two-entry response FIFO; the credit rule keeps push from ever hitting a full FIFO.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
      fifo_last_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      if (push) begin
        fifo_data_q[wr_ptr_q] <= ram_d_i;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
